// File: rtl/conv3x3_accum_pkg.sv
// Shared constants, types and helpers for the 3x3 convolution accumulator.
package conv3x3_accum_pkg;

    localparam int unsigned IMG_ROWS = 200;
    localparam int unsigned IMG_COLS = 300;
    localparam int unsigned SHIFT    = 4;
    localparam int unsigned NTAPS    = 9;
    localparam int unsigned COEF_W   = 8;
    localparam int unsigned PIX_W    = 8;
    localparam int unsigned PROD_W   = 17;
    localparam int unsigned ACC_W    = 21;
    localparam int unsigned ADDR_W   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2,
        EMIT  = 2'd3
    } state_t;

    typedef logic signed [COEF_W-1:0] coef_t;

    // Captured tap waiting for its pixel on the following cycle.
    typedef struct packed {
        logic [3:0] k;
        logic       in_range;
    } tap_t;

    // Default Gaussian kernel 1 2 1 / 2 4 2 / 1 2 1, indexed row*3+col.
    function automatic coef_t default_coef(input logic [3:0] k);
        case (k)
            4'd0, 4'd2, 4'd6, 4'd8: return coef_t'(8'sd1);
            4'd1, 4'd3, 4'd5, 4'd7: return coef_t'(8'sd2);
            4'd4:                   return coef_t'(8'sd4);
            default:                return coef_t'(8'sd0);
        endcase
    endfunction

    // Arithmetic right shift by SHIFT, then saturate to 0..255.
    function automatic logic [PIX_W-1:0] clamp_u8(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = a >>> SHIFT;
        if (s[ACC_W-1])
            return '0;
        else if (|s[ACC_W-2:PIX_W])
            return '1;
        else
            return s[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/conv3x3_accum_if.sv
// Tap, coefficient and result signals between address generator and accumulator.
interface conv3x3_accum_if;
    logic        data_in;
    logic [1:0]  row_in;
    logic [1:0]  col_in;
    logic [7:0]  pxl_row;
    logic [8:0]  pxl_col;
    logic [7:0]  pix_data;
    logic        write_enable;
    logic [7:0]  out_pxl_row;
    logic [8:0]  out_pxl_col;
    logic        done;
    logic        coef_we;
    logic [3:0]  coef_addr;
    logic signed [7:0] coef_data;
    logic        out_we;
    logic [15:0] out_addr;
    logic [7:0]  out_data;
    logic        frame_done;
    logic        tap_err;

    modport master (
        output data_in, row_in, col_in, pxl_row, pxl_col, pix_data, write_enable,
               out_pxl_row, out_pxl_col, done, coef_we, coef_addr, coef_data,
        input  out_we, out_addr, out_data, frame_done, tap_err
    );

    modport slave (
        input  data_in, row_in, col_in, pxl_row, pxl_col, pix_data, write_enable,
               out_pxl_row, out_pxl_col, done, coef_we, coef_addr, coef_data,
        output out_we, out_addr, out_data, frame_done, tap_err
    );
endinterface

// File: rtl/conv_coef_rf.sv
// Nine signed kernel coefficients; reset loads the default kernel.
module conv_coef_rf
    import conv3x3_accum_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic [3:0] waddr,
    input  coef_t      wdata,
    input  logic [3:0] raddr,
    output coef_t      rdata_c
);

    coef_t regs [NTAPS];

    // Coefficient storage; writes beyond the last tap are dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NTAPS; i++)
                regs[i] <= default_coef(4'(i));
        end else if (we && (waddr <= 4'(NTAPS - 1))) begin
            regs[waddr] <= wdata;
        end
    end

    // Asynchronous read of the coefficient for the pending tap.
    always_comb begin
        rdata_c = '0;
        if (raddr <= 4'(NTAPS - 1))
            rdata_c = regs[raddr];
    end

endmodule

// File: rtl/conv3x3_accum.sv
// Accumulates nine coefficient*pixel taps per window and writes the clamped result.
module conv3x3_accum
    import conv3x3_accum_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    conv3x3_accum_if.slave  bus
);

    state_t                    state_q, state_d;
    logic [NTAPS-1:0]          mask_q;
    logic signed [ACC_W-1:0]   acc_q;
    tap_t                      pend_q;
    logic                      pend_vld_q;
    logic                      we_prev_q;
    logic                      done_prev_q;

    logic [3:0]                tap_k_c;
    logic                      in_range_c;
    logic                      t_c;
    logic                      cap_c;
    logic [15:0]               mask_ext_c;
    coef_t                     coef_c;
    logic signed [PIX_W:0]     pix9_c;
    logic signed [PROD_W-1:0]  prod_c;

    conv_coef_rf u_coef_rf (
        .clk     (clk),
        .reset   (reset),
        .we      (bus.coef_we),
        .waddr   (bus.coef_addr),
        .wdata   (bus.coef_data),
        .raddr   (pend_q.k),
        .rdata_c (coef_c)
    );

    // Tap decode, window-close detection and product of the pending tap.
    always_comb begin
        tap_k_c    = 4'(bus.row_in) * 4'd3 + 4'(bus.col_in);
        in_range_c = (bus.pxl_row <= 8'(IMG_ROWS - 1)) && (bus.pxl_col <= 9'(IMG_COLS - 1));
        t_c        = bus.write_enable && !we_prev_q && !bus.done;
        mask_ext_c = {7'd0, mask_q};
        cap_c      = bus.data_in && !bus.done && !t_c
                     && (tap_k_c <= 4'(NTAPS - 1)) && !mask_ext_c[tap_k_c];
        pix9_c     = pend_q.in_range ? $signed({1'b0, bus.pix_data}) : '0;
        prod_c     = PROD_W'(coef_c) * PROD_W'(pix9_c);
    end

    // Pipeline state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic; a window close from any accumulating state flushes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (t_c) state_d = FLUSH;
                     else if (cap_c) state_d = ACCUM;
            ACCUM:   if (t_c) state_d = FLUSH;
            FLUSH:   state_d = EMIT;
            EMIT:    if (t_c) state_d = FLUSH;
                     else if (pend_vld_q || cap_c) state_d = ACCUM;
                     else state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture mask, accumulator, error flag and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q         <= '0;
            acc_q          <= '0;
            pend_q         <= '0;
            pend_vld_q     <= 1'b0;
            we_prev_q      <= 1'b0;
            done_prev_q    <= 1'b0;
            bus.out_we     <= 1'b0;
            bus.out_addr   <= '0;
            bus.out_data   <= '0;
            bus.frame_done <= 1'b0;
            bus.tap_err    <= 1'b0;
        end else begin
            we_prev_q      <= bus.write_enable;
            done_prev_q    <= bus.done;
            bus.frame_done <= bus.done && !done_prev_q;
            bus.out_we     <= (state_q == FLUSH);
            pend_vld_q     <= cap_c;
            pend_q         <= '{k: tap_k_c, in_range: in_range_c};

            if (t_c)
                mask_q <= '0;
            else if (cap_c)
                mask_q <= mask_q | NTAPS'(16'd1 << tap_k_c);

            if (t_c) begin
                bus.out_addr <= 16'(bus.out_pxl_row) * 16'(IMG_COLS) + 16'(bus.out_pxl_col);
                if (mask_q != '1)
                    bus.tap_err <= 1'b1;
            end

            if (state_q == FLUSH) begin
                bus.out_data <= clamp_u8(acc_q);
                acc_q        <= '0;
            end else if (pend_vld_q) begin
                acc_q <= acc_q + ACC_W'(prod_c);
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_accum.sv
// Self-checking bench for conv3x3_accum with a window-level reference model.
module tb_conv3x3_accum;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    conv3x3_accum_if bus ();

    conv3x3_accum dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int mcoef [9];
    int err_sticky;
    int pend_pix;
    int tr [$];
    int tc [$];
    int tpr [$];
    int tpc [$];
    int tpx [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        int dk [9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
        for (int i = 0; i < 9; i++) mcoef[i] = dk[i];
        err_sticky = 0;
        pend_pix   = 0;
    endtask

    // One clock cycle; pix_data carries the pixel for the previous cycle's address.
    task automatic step(input bit din, input int r, input int c, input int pr, input int pc,
                        input int px, input bit we);
        bus.data_in      = din;
        bus.row_in       = 2'(r);
        bus.col_in       = 2'(c);
        bus.pxl_row      = 8'(pr);
        bus.pxl_col      = 9'(pc);
        bus.pix_data     = 8'(pend_pix);
        bus.write_enable = we;
        @(posedge clk);
        #1;
        pend_pix = px;
    endtask

    task automatic wcoef(input int addr, input int data);
        bus.coef_we   = 1'b1;
        bus.coef_addr = 4'(addr);
        bus.coef_data = 8'(data);
        @(posedge clk);
        #1;
        bus.coef_we = 1'b0;
        if (addr <= 8) mcoef[addr] = data;
    endtask

    task automatic add_tap(input int r, input int c, input int pr, input int pc, input int px);
        tr.push_back(r); tc.push_back(c); tpr.push_back(pr); tpc.push_back(pc); tpx.push_back(px);
    endtask

    task automatic add_full(input int px);
        for (int k = 0; k < 9; k++) add_tap(k / 3, k % 3, 10 + k, 20 + k, px);
    endtask

    // Drive the queued taps, close the window, and check the result at T+2.
    task automatic run_window(input string tag, input int orow, input int ocol, input bit pulse_chk);
        int sum = 0;
        int mask = 0;
        int k, p, res;
        foreach (tr[i]) begin
            k = tr[i] * 3 + tc[i];
            step(1'b1, tr[i], tc[i], tpr[i], tpc[i], tpx[i], 1'b0);
            if (((mask >> k) & 1) == 0) begin
                mask |= (1 << k);
                p = (tpr[i] <= 199 && tpc[i] <= 299) ? tpx[i] : 0;
                sum += mcoef[k] * p;
            end
        end
        if (mask != 9'h1FF) err_sticky = 1;
        res = sum >>> 4;
        if (res < 0) res = 0;
        if (res > 255) res = 255;
        bus.out_pxl_row = 8'(orow);
        bus.out_pxl_col = 9'(ocol);
        step(1'b1, 1, 1, 5, 5, 77, 1'b1);
        bus.out_pxl_row = 8'hAA;
        bus.out_pxl_col = 9'h155;
        step(1'b0, 0, 0, 0, 0, 0, 1'b1);
        check({tag, ".out_we"}, 32'(bus.out_we), 32'd1);
        check({tag, ".out_data"}, 32'(bus.out_data), 32'(res));
        check({tag, ".out_addr"}, 32'(bus.out_addr), 32'(orow * 300 + ocol));
        check({tag, ".tap_err"}, 32'(bus.tap_err), 32'(err_sticky));
        tr.delete(); tc.delete(); tpr.delete(); tpc.delete(); tpx.delete();
        if (pulse_chk) begin
            step(1'b0, 0, 0, 0, 0, 0, 1'b0);
            check({tag, ".out_we_pulse"}, 32'(bus.out_we), 32'd0);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, ".out_we"}, 32'(bus.out_we), 32'd0);
        check({tag, ".out_data"}, 32'(bus.out_data), 32'd0);
        check({tag, ".out_addr"}, 32'(bus.out_addr), 32'd0);
        check({tag, ".frame_done"}, 32'(bus.frame_done), 32'd0);
        check({tag, ".tap_err"}, 32'(bus.tap_err), 32'd0);
    endtask

    initial begin
        int perm [9];
        int tmp, j, pr, pc;

        bus.data_in = 0; bus.row_in = 0; bus.col_in = 0; bus.pxl_row = 0; bus.pxl_col = 0;
        bus.pix_data = 0; bus.write_enable = 0; bus.out_pxl_row = 0; bus.out_pxl_col = 0;
        bus.done = 0; bus.coef_we = 0; bus.coef_addr = 0; bus.coef_data = 0;
        model_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        #2 reset = 1'b1;
        step(1'b0, 0, 0, 0, 0, 0, 1'b0);

        // Default kernel, flat image of 100.
        add_full(100);
        run_window("gauss100", 0, 0, 1'b1);

        // Negative saturation; also writes to unused coefficient addresses.
        for (int k = 0; k < 9; k++) wcoef(k, -128);
        for (int a = 9; a < 16; a++) wcoef(a, 99);
        add_full(255);
        run_window("neg_clamp", 3, 7, 1'b1);

        // Positive saturation.
        for (int k = 0; k < 9; k++) wcoef(k, 127);
        add_full(255);
        run_window("pos_clamp", 100, 150, 1'b1);

        // Repeated strobes of the centre tap; incomplete window raises tap_err.
        wcoef(4, 16);
        add_tap(1, 1, 50, 50, 16);
        add_tap(1, 1, 50, 51, 200);
        add_tap(1, 1, 50, 52, 200);
        run_window("single_tap", 12, 34, 1'b1);

        // Out-of-range taps contribute nothing; last image address.
        wcoef(0, 1); wcoef(1, 2); wcoef(2, 1); wcoef(3, 2); wcoef(4, 4);
        wcoef(5, 2); wcoef(6, 1); wcoef(7, 2); wcoef(8, 1);
        for (int k = 0; k < 9; k++) begin
            if (k == 0)      add_tap(0, 0, 201, 10, 255);
            else if (k == 1) add_tap(0, 1, 10, 301, 255);
            else if (k == 5) add_tap(1, 2, 201, 301, 255);
            else             add_tap(k / 3, k % 3, 199, 299, 100);
        end
        run_window("oob", 199, 299, 1'b1);

        // Back-to-back windows: next window's taps start at T+2.
        add_full(40);
        run_window("b2b_a", 1, 2, 1'b0);
        add_full(200);
        run_window("b2b_b", 3, 4, 1'b1);

        // Randomized coefficients, tap order, duplicates, skips and coordinates.
        for (int w = 0; w < 8; w++) begin
            for (int n = 0; n < 3; n++)
                wcoef(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)) - 128);
            for (int k = 0; k < 9; k++) perm[k] = k;
            for (int k = 8; k > 0; k--) begin
                j = int'($urandom_range(0, k));
                tmp = perm[k]; perm[k] = perm[j]; perm[j] = tmp;
            end
            for (int k = 0; k < 9; k++) begin
                if ($urandom_range(0, 11) == 0) continue;
                pr = ($urandom_range(0, 9) == 0) ? int'($urandom_range(200, 255)) : int'($urandom_range(0, 199));
                pc = ($urandom_range(0, 9) == 0) ? int'($urandom_range(300, 511)) : int'($urandom_range(0, 299));
                add_tap(perm[k] / 3, perm[k] % 3, pr, pc, int'($urandom_range(0, 255)));
                if ($urandom_range(0, 7) == 0)
                    add_tap(perm[k] / 3, perm[k] % 3, pr, pc, int'($urandom_range(0, 255)));
            end
            run_window($sformatf("rand%0d", w), int'($urandom_range(0, 199)),
                       int'($urandom_range(0, 299)), 1'(w == 7));
        end

        // Frame done: one-cycle pulse; taps and window closes ignored; coef writes allowed.
        bus.done = 1'b1;
        step(1'b0, 0, 0, 0, 0, 0, 1'b0);
        check("frame_done.rise", 32'(bus.frame_done), 32'd1);
        step(1'b1, 0, 0, 10, 10, 250, 1'b0);
        check("frame_done.pulse", 32'(bus.frame_done), 32'd0);
        step(1'b0, 0, 0, 0, 0, 0, 1'b1);
        step(1'b0, 0, 0, 0, 0, 0, 1'b1);
        step(1'b0, 0, 0, 0, 0, 0, 1'b0);
        check("done.no_out_we0", 32'(bus.out_we), 32'd0);
        step(1'b0, 0, 0, 0, 0, 0, 1'b0);
        check("done.no_out_we1", 32'(bus.out_we), 32'd0);
        wcoef(0, 5);
        bus.done = 1'b0;
        step(1'b0, 0, 0, 0, 0, 0, 1'b0);
        add_full(10);
        run_window("after_done", 7, 8, 1'b1);

        // Reset at T+1 discards the window and restores the default kernel.
        add_full(90);
        foreach (tr[i]) step(1'b1, tr[i], tc[i], tpr[i], tpc[i], tpx[i], 1'b0);
        tr.delete(); tc.delete(); tpr.delete(); tpc.delete(); tpx.delete();
        bus.out_pxl_row = 8'd5;
        bus.out_pxl_col = 9'd6;
        step(1'b0, 0, 0, 0, 0, 0, 1'b1);
        reset = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        model_reset();
        bus.write_enable = 1'b0;
        bus.data_in      = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step(1'b0, 0, 0, 0, 0, 0, 1'b0);
            check($sformatf("post_reset.no_out_we%0d", n), 32'(bus.out_we), 32'd0);
        end
        add_full(100);
        run_window("post_reset_default", 0, 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
